// File: rtl/bram_rd_devmux_if.sv
// Bus bundle between the AXI BRAM read channel, the device mux and up to four
// read devices.
interface bram_rd_devmux_if #(
  parameter int ADDRESS_BITS = 10
);
  logic                    start_burst;
  logic [ADDRESS_BITS-1:0] pre_araddr;
  logic [3:0]              burst_len;
  logic                    bram_ren;
  logic                    dev_ready;
  logic [31:0]             rdata;
  logic [3:0]              dev_rdy_in;
  logic [31:0]             dev_rdata0;
  logic [31:0]             dev_rdata1;
  logic [31:0]             dev_rdata2;
  logic [31:0]             dev_rdata3;
  logic [3:0]              dev_ren;
  logic                    busy;
  logic                    err_timeout;
  logic                    err_unmapped;
  logic [1:0]              err_dev;
  logic                    err_clr;

  modport slave (
    input  start_burst, pre_araddr, burst_len, bram_ren, dev_rdy_in,
           dev_rdata0, dev_rdata1, dev_rdata2, dev_rdata3, err_clr,
    output dev_ready, rdata, dev_ren, busy, err_timeout, err_unmapped, err_dev
  );

  modport master (
    output start_burst, pre_araddr, burst_len, bram_ren, dev_rdy_in,
           dev_rdata0, dev_rdata1, dev_rdata2, dev_rdata3, err_clr,
    input  dev_ready, rdata, dev_ren, busy, err_timeout, err_unmapped, err_dev
  );
endinterface

// File: rtl/bram_rd_devmux.sv
// Routes AXI BRAM read bursts to one of four devices chosen by the top address
// bits, with stall timeout, unmapped-device forcing and sticky error flags.
module bram_rd_devmux #(
  parameter int         ADDRESS_BITS = 10,
  parameter logic [3:0] DEV_EN       = 4'b1111,
  parameter logic [7:0] TIMEOUT      = 8'd255
) (
  input logic               aclk,
  input logic               rst,
  bram_rd_devmux_if.slave   io_bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] FORCED = 2'd2;

  logic [1:0] r_state, w_state_nxt;
  logic [1:0] r_sel, w_sel_nxt;
  logic [3:0] r_beats, w_beats_nxt;
  logic [7:0] r_stall, w_stall_nxt;
  logic       r_err_to, w_err_to_nxt;
  logic       r_err_un, w_err_un_nxt;
  logic [1:0] r_err_dev, w_err_dev_nxt;
  logic [1:0] r_sel_d1, r_sel_d2;
  logic       r_force_d1, r_force_d2;

  logic       w_dev_ready;
  logic [3:0] w_dev_ren;
  logic [31:0] w_rdata;
  logic [1:0] w_start_sel;
  logic       w_burst_end;
  logic       w_take_start;
  logic       w_new_to;
  logic       w_new_un;
  logic       w_unused_addr;

  assign w_start_sel   = io_bus.pre_araddr[ADDRESS_BITS-1 -: 2];
  assign w_unused_addr = ^io_bus.pre_araddr[ADDRESS_BITS-3:0];

  // Ready depends only on registered state so start_burst never loops back into it.
  always_comb begin
    w_dev_ready = 1'b1;
    w_dev_ren   = 4'b0000;
    if (r_state == ACTIVE) begin
      w_dev_ready = io_bus.dev_rdy_in[r_sel];
      w_dev_ren   = 4'(io_bus.bram_ren) << r_sel;
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    if (!r_force_d2) begin
      unique case (r_sel_d2)
        2'd0:    w_rdata = io_bus.dev_rdata0;
        2'd1:    w_rdata = io_bus.dev_rdata1;
        2'd2:    w_rdata = io_bus.dev_rdata2;
        default: w_rdata = io_bus.dev_rdata3;
      endcase
    end
  end

  assign w_burst_end  = (r_state != IDLE) && io_bus.bram_ren && (r_beats == 4'd0);
  assign w_take_start = io_bus.start_burst && ((r_state == IDLE) || w_burst_end);

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_beats_nxt   = r_beats;
    w_stall_nxt   = 8'd0;
    w_err_dev_nxt = r_err_dev;
    w_new_to      = 1'b0;
    w_new_un      = 1'b0;

    if (r_state == ACTIVE && !w_dev_ready) begin
      if (r_stall == TIMEOUT - 8'd1) begin
        w_new_to      = 1'b1;
        w_err_dev_nxt = r_sel;
        w_state_nxt   = FORCED;
      end else begin
        w_stall_nxt = r_stall + 8'd1;
      end
    end

    if (w_burst_end) begin
      w_state_nxt = IDLE;
    end else if (r_state != IDLE && io_bus.bram_ren) begin
      w_beats_nxt = r_beats - 4'd1;
    end

    // A start at burst end overrides the return to IDLE (back-to-back bursts).
    if (w_take_start) begin
      w_sel_nxt   = w_start_sel;
      w_beats_nxt = io_bus.burst_len;
      w_stall_nxt = 8'd0;
      if (DEV_EN[w_start_sel]) begin
        w_state_nxt = ACTIVE;
      end else begin
        w_state_nxt   = FORCED;
        w_new_un      = 1'b1;
        w_err_dev_nxt = w_start_sel;
      end
    end

    w_err_to_nxt = (r_err_to & ~io_bus.err_clr) | w_new_to;
    w_err_un_nxt = (r_err_un & ~io_bus.err_clr) | w_new_un;
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sel     <= 2'd0;
      r_beats   <= 4'd0;
      r_stall   <= 8'd0;
      r_err_to  <= 1'b0;
      r_err_un  <= 1'b0;
      r_err_dev <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_beats   <= w_beats_nxt;
      r_stall   <= w_stall_nxt;
      r_err_to  <= w_err_to_nxt;
      r_err_un  <= w_err_un_nxt;
      r_err_dev <= w_err_dev_nxt;
    end
  end

  // Data select tracks the BRAM's two-stage read pipeline, advanced per ren.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_sel_d1   <= 2'd0;
      r_sel_d2   <= 2'd0;
      r_force_d1 <= 1'b0;
      r_force_d2 <= 1'b0;
    end else if (io_bus.bram_ren) begin
      r_sel_d1   <= r_sel;
      r_force_d1 <= (r_state == FORCED);
      r_sel_d2   <= r_sel_d1;
      r_force_d2 <= r_force_d1;
    end
  end

  assign io_bus.dev_ready    = w_dev_ready;
  assign io_bus.dev_ren      = w_dev_ren;
  assign io_bus.rdata        = w_rdata;
  assign io_bus.busy         = (r_state != IDLE);
  assign io_bus.err_timeout  = r_err_to;
  assign io_bus.err_unmapped = r_err_un;
  assign io_bus.err_dev      = r_err_dev;
endmodule

// File: doc/bram_rd_devmux.md
BRAM_RD_DEVMUX -- requirements
Module: bram_rd_devmux

Interface
REQ-001 Parameter ADDRESS_BITS, default 10, width of pre_araddr; bits [ADDRESS_BITS-1:ADDRESS_BITS-2] select the device.
REQ-002 Parameter DEV_EN, default 4'b1111, one bit per device; 0 = unmapped.
REQ-003 Parameter TIMEOUT, default 255, 8-bit stall limit in cycles.
REQ-004 aclk  input  1  clock for all logic.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start_burst  input  1  burst start pulse from the AXI BRAM read channel.
REQ-007 pre_araddr  input  ADDRESS_BITS  burst start address, valid with start_burst.
REQ-008 burst_len  input  4  beats minus one, valid with start_burst.
REQ-009 bram_ren  input  1  read enable from the read channel; one pulse per beat.
REQ-010 dev_ready  output  1  multiplexed ready back to the read channel.
REQ-011 rdata  output  32  multiplexed read data back to the read channel.
REQ-012 dev_rdy_in  input  4  per-device ready.
REQ-013 dev_rdata0..dev_rdata3  input  32 each  per-device read data.
REQ-014 dev_ren  output  4  one-hot forwarded read enable.
REQ-015 busy  output  1  burst active.
REQ-016 err_timeout, err_unmapped  output  1 each  sticky error flags.
REQ-017 err_dev  output  2  device index of the most recent error.
REQ-018 err_clr  input  1  synchronous clear of the error flags.

Function
REQ-019 FSM states: IDLE, ACTIVE, FORCED; state encoding is free.
REQ-020 IDLE -> ACTIVE on start_burst; sel_r <= pre_araddr top 2 bits; beat counter <= burst_len; stall counter <= 0.
REQ-021 In ACTIVE, each bram_ren decrements the beat counter. On bram_ren with counter == 0 the burst ends: -> IDLE, or restarts ACTIVE the same cycle if start_burst is also asserted (back-to-back).
REQ-022 dev_ready shall use only the registered sel_r, never pre_araddr combinationally (no loop through start_burst). In IDLE, dev_ready = 1.
REQ-023 ACTIVE, mapped device: dev_ready = dev_rdy_in[sel_r]; dev_ren = bram_ren one-hot on sel_r.
REQ-024 Unmapped device (DEV_EN[sel] == 0) at start: the FSM enters FORCED directly; set err_unmapped and err_dev = sel.
REQ-025 Stall counter: increments each ACTIVE cycle with dev_ready == 0 and clears on any cycle with dev_ready == 1. On reaching TIMEOUT -> FORCED; set err_timeout and err_dev = sel_r.
REQ-026 FORCED: dev_ready = 1, dev_ren = 0, returned data = 0. Beat counting and burst-end/back-to-back rules as in ACTIVE; a new burst re-enters ACTIVE or FORCED per REQ-020/REQ-024.
REQ-027 Data select pipeline: {sel_d1, force_d1} <= {sel_r, forced} on bram_ren; {sel_d2, force_d2} <= {sel_d1, force_d1} on bram_ren.
REQ-028 rdata = force_d2 ? 0 : dev_rdata[sel_d2] (combinational, 2-ren latency matching the BRAM register pipeline).
REQ-029 Error flags are sticky until err_clr. err_clr coinciding with a new error: the new error wins.
REQ-030 busy = (state != IDLE).
REQ-031 bram_ren while IDLE shall be ignored for counting but still advances the data select pipeline.

Reset
REQ-032 On rst: state IDLE; sel_r, sel_d1, sel_d2, counters, err_dev = 0; force_d1, force_d2, err flags = 0; dev_ren = 0; dev_ready = 1; busy = 0.
REQ-033 rst mid-burst aborts immediately with no further dev_ren pulses; the next start_burst is handled normally.

Verification
REQ-034 Device 2, burst_len 3, dev_rdy_in all 1, four bram_ren -> dev_ren = 4'b0100 x4, rdata = dev_rdata2 two rens later, busy drops after the 4th ren.
REQ-035 Back-to-back: last ren of a device-1 burst coincides with start_burst to device 3 -> last beat goes to device 1, next beats to device 3 with no idle cycle.
REQ-036 Device 0 holds dev_rdy_in[0] = 0 for 300 cycles -> FORCED after 255 stall cycles, err_timeout = 1, err_dev = 0, rdata = 0 for the remaining beats.
REQ-037 DEV_EN = 4'b0111, burst to device 3 -> FORCED immediately, dev_ready = 1, dev_ren = 0, err_unmapped = 1, err_dev = 3.
REQ-038 err_clr pulse -> flags = 0; rst asserted mid-burst -> busy = 0 and dev_ready = 1 immediately.
